// File: rtl/maxpool_ctrl_pkg.sv
// Shared types and sizing helpers for the 2x2 max-pool frame sequencer.
package maxpool_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CLEAR = 3'd1,
        ST_RUN   = 3'd2,
        ST_DRAIN = 3'd3,
        ST_DONE  = 3'd4
    } state_e;

    // Index width for a count of n positions; never narrower than one bit.
    function automatic int unsigned idx_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int unsigned DEF_IN_WIDTH  = 24;
    localparam int unsigned DEF_IN_HEIGHT = 24;
    localparam int unsigned DEF_IN_COL_W  = idx_w(DEF_IN_WIDTH);
    localparam int unsigned DEF_IN_ROW_W  = idx_w(DEF_IN_HEIGHT);
    localparam int unsigned DEF_OUT_COL_W = idx_w(DEF_IN_WIDTH / 2);
    localparam int unsigned DEF_OUT_ROW_W = idx_w(DEF_IN_HEIGHT / 2);

endpackage

// File: rtl/maxpool_pos_counter.sv
// Row/column raster position counter that wraps modulo the frame dimensions.
module maxpool_pos_counter
    import maxpool_ctrl_pkg::*;
#(
    parameter int unsigned WIDTH  = 2,
    parameter int unsigned HEIGHT = 2
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      clr,
    input  logic                      inc,
    output logic [idx_w(WIDTH)-1:0]   col,
    output logic [idx_w(HEIGHT)-1:0]  row,
    output logic                      last
);

    localparam int unsigned CW = idx_w(WIDTH);
    localparam int unsigned RW = idx_w(HEIGHT);
    localparam logic [CW-1:0] COL_MAX = CW'(WIDTH - 1);
    localparam logic [RW-1:0] ROW_MAX = RW'(HEIGHT - 1);

    logic [CW-1:0] col_q, col_d;
    logic [RW-1:0] row_q, row_d;

    // Next position: clear wins, otherwise step in raster order with wrap.
    always_comb begin
        col_d = col_q;
        row_d = row_q;
        if (clr) begin
            col_d = {CW{1'b0}};
            row_d = {RW{1'b0}};
        end else if (inc) begin
            if (col_q == COL_MAX) begin
                col_d = {CW{1'b0}};
                if (row_q == ROW_MAX) begin
                    row_d = {RW{1'b0}};
                end else begin
                    row_d = row_q + RW'(1);
                end
            end else begin
                col_d = col_q + CW'(1);
                row_d = row_q;
            end
        end else begin
            col_d = col_q;
            row_d = row_q;
        end
    end

    // Position registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col_q <= {CW{1'b0}};
            row_q <= {RW{1'b0}};
        end else begin
            col_q <= col_d;
            row_q <= row_d;
        end
    end

    assign col  = col_q;
    assign row  = row_q;
    assign last = (col_q == COL_MAX) && (row_q == ROW_MAX);

endmodule

// File: rtl/maxpool_frame_ctrl.sv
// Frame sequencer for the 2x2 max-pool/ReLU stage: clear, gate, tag outputs, report.
module maxpool_frame_ctrl
    import maxpool_ctrl_pkg::*;
#(
    parameter int unsigned IN_WIDTH      = DEF_IN_WIDTH,
    parameter int unsigned IN_HEIGHT     = DEF_IN_HEIGHT,
    parameter int unsigned DRAIN_TIMEOUT = 4
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            start,
    input  logic                            conv_valid,
    output logic                            pool_valid_in,
    output logic                            pool_clr_n,
    input  logic                            pool_valid_out,
    output logic                            out_valid,
    output logic [idx_w(IN_HEIGHT/2)-1:0]   out_row,
    output logic [idx_w(IN_WIDTH/2)-1:0]    out_col,
    output logic                            frame_last,
    output logic                            busy,
    output logic                            done,
    output logic                            err_unexpected,
    output logic                            err_timeout
);

    localparam int unsigned ICW = idx_w(IN_WIDTH);
    localparam int unsigned IRW = idx_w(IN_HEIGHT);
    localparam int unsigned TW  = idx_w(DRAIN_TIMEOUT);
    localparam logic [TW-1:0] TMO_MAX = TW'(DRAIN_TIMEOUT - 1);

    state_e        state_q, state_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic          err_unexp_q, err_unexp_d;
    logic          err_tmo_q, err_tmo_d;
    logic          pool_clr_n_q, pool_clr_n_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;

    logic           start_ok_s, accept_s, out_valid_s, in_last_s, out_last_s;
    logic           frame_last_s, tmo_hit_s, unused_pos_s;
    logic [ICW-1:0] in_col_s;
    logic [IRW-1:0] in_row_s;

    assign start_ok_s   = (state_q == ST_IDLE) && start;
    assign accept_s     = (state_q == ST_RUN) && conv_valid;
    assign out_valid_s  = pool_valid_out && ((state_q == ST_RUN) || (state_q == ST_DRAIN));
    assign frame_last_s = out_valid_s && out_last_s;
    assign tmo_hit_s    = (state_q == ST_DRAIN) && !frame_last_s && (tmo_q == TMO_MAX);
    assign unused_pos_s = ^{in_row_s, in_col_s};

    maxpool_pos_counter #(.WIDTH(IN_WIDTH), .HEIGHT(IN_HEIGHT)) u_in_pos (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (start_ok_s),
        .inc   (accept_s),
        .col   (in_col_s),
        .row   (in_row_s),
        .last  (in_last_s)
    );

    maxpool_pos_counter #(.WIDTH(IN_WIDTH / 2), .HEIGHT(IN_HEIGHT / 2)) u_out_pos (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (start_ok_s),
        .inc   (out_valid_s),
        .col   (out_col),
        .row   (out_row),
        .last  (out_last_s)
    );

    // Next-state, timeout count, sticky errors and registered-output next values.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  state_d = start ? ST_CLEAR : ST_IDLE;
            ST_CLEAR: state_d = ST_RUN;
            ST_RUN:   state_d = (accept_s && in_last_s) ? ST_DRAIN : ST_RUN;
            ST_DRAIN: state_d = (frame_last_s || tmo_hit_s) ? ST_DONE : ST_DRAIN;
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase

        if (state_q == ST_DRAIN) begin
            tmo_d = tmo_q + TW'(1);
        end else begin
            tmo_d = {TW{1'b0}};
        end

        // A stray pixel in the same cycle as start is still reported.
        if (conv_valid && (state_q != ST_RUN)) begin
            err_unexp_d = 1'b1;
        end else if (start_ok_s) begin
            err_unexp_d = 1'b0;
        end else begin
            err_unexp_d = err_unexp_q;
        end

        if (tmo_hit_s) begin
            err_tmo_d = 1'b1;
        end else if (start_ok_s) begin
            err_tmo_d = 1'b0;
        end else begin
            err_tmo_d = err_tmo_q;
        end

        pool_clr_n_d = (state_d == ST_RUN) || (state_d == ST_DRAIN) || (state_d == ST_DONE);
        busy_d       = (state_d == ST_CLEAR) || (state_d == ST_RUN) || (state_d == ST_DRAIN);
        done_d       = (state_d == ST_DONE);
    end

    // Control state and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            tmo_q        <= {TW{1'b0}};
            err_unexp_q  <= 1'b0;
            err_tmo_q    <= 1'b0;
            pool_clr_n_q <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            tmo_q        <= tmo_d;
            err_unexp_q  <= err_unexp_d;
            err_tmo_q    <= err_tmo_d;
            pool_clr_n_q <= pool_clr_n_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
        end
    end

    assign pool_valid_in  = accept_s;
    assign out_valid      = out_valid_s;
    assign frame_last     = frame_last_s;
    assign pool_clr_n     = pool_clr_n_q;
    assign busy           = busy_q;
    assign done           = done_q;
    assign err_unexpected = err_unexp_q;
    assign err_timeout    = err_tmo_q;

endmodule

// File: tb/tb_maxpool_frame_ctrl.sv
// Directed/randomized bench for maxpool_frame_ctrl; the bench itself plays the pool unit.
module tb_maxpool_frame_ctrl;

    localparam int IW   = 24;
    localparam int IH   = 24;
    localparam int OW   = IW / 2;
    localparam int NPIX = IW * IH;
    localparam int NOUT = (IW / 2) * (IH / 2);
    localparam int DTO  = 4;

    logic       clk = 1'b0;
    logic       rst_n, start, conv_valid, pool_valid_out;
    logic       pool_valid_in, pool_clr_n, out_valid, frame_last;
    logic [3:0] out_row, out_col;
    logic       busy, done, err_unexpected, err_timeout;

    int checks = 0;
    int errors = 0;
    int obs_outs = 0;
    bit exp_eu = 1'b0;
    bit exp_et = 1'b0;

    maxpool_frame_ctrl #(.IN_WIDTH(IW), .IN_HEIGHT(IH), .DRAIN_TIMEOUT(DTO)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .start          (start),
        .conv_valid     (conv_valid),
        .pool_valid_in  (pool_valid_in),
        .pool_clr_n     (pool_clr_n),
        .pool_valid_out (pool_valid_out),
        .out_valid      (out_valid),
        .out_row        (out_row),
        .out_col        (out_col),
        .frame_last     (frame_last),
        .busy           (busy),
        .done           (done),
        .err_unexpected (err_unexpected),
        .err_timeout    (err_timeout)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // One cycle: drive inputs after the falling edge, then settle before checks.
    task automatic drive(input logic cv, input logic st, input logic pvo);
        @(negedge clk);
        conv_valid     = cv;
        start          = st;
        pool_valid_out = pvo;
        #1;
        if (out_valid === 1'b1) obs_outs++;
    endtask

    task automatic chk_errs(input string tag);
        chk({tag, "_eu"}, err_unexpected, exp_eu);
        chk({tag, "_et"}, err_timeout, exp_et);
    endtask

    task automatic do_reset();
        @(negedge clk);
        conv_valid = 1'b0; start = 1'b0; pool_valid_out = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_clrn", pool_clr_n, 0);
        chk("rst_row", out_row, 0);
        chk("rst_col", out_col, 0);
        chk("rst_eu", err_unexpected, 0);
        chk("rst_et", err_timeout, 0);
        chk("rst_pvi", pool_valid_in, 0);
        chk("rst_ov", out_valid, 0);
        exp_eu = 1'b0;
        exp_et = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // One frame. vpct: conv_valid density; withhold: drop the final pooled output;
    // hold_st: keep start high throughout; drain_cv: stray pixel in DRAIN; abort_at: stop early.
    task automatic run_frame(input int vpct, input bit withhold, input bit hold_st,
                             input bit drain_cv, input int abort_at);
        int   p, n, r, c;
        logic cv;
        bit   pend, nxt;
        obs_outs = 0;
        drive(1'b0, 1'b1, 1'b0);
        chk("idle_busy", busy, 0);
        chk("idle_clrn", pool_clr_n, 0);
        chk_errs("idle");
        exp_eu = 1'b0;
        exp_et = 1'b0;
        drive(1'b0, hold_st, 1'b0);
        chk("clr_busy", busy, 1);
        chk("clr_clrn", pool_clr_n, 0);
        chk_errs("clr");
        p = 0; n = 0; pend = 1'b0;
        while (p < NPIX) begin
            if (p == abort_at) return;
            cv = ($urandom_range(99) < vpct) ? 1'b1 : 1'b0;
            drive(cv, hold_st, pend);
            chk("run_pvi", pool_valid_in, cv);
            chk("run_clrn", pool_clr_n, 1);
            chk("run_busy", busy, 1);
            chk("run_done", done, 0);
            chk("run_ov", out_valid, pend);
            if (pend) begin
                chk("run_row", out_row, n / OW);
                chk("run_col", out_col, n % OW);
                chk("run_last", frame_last, (n == NOUT - 1) ? 1 : 0);
                n++;
            end
            nxt = 1'b0;
            if (cv) begin
                r = p / IW;
                c = p % IW;
                nxt = (r % 2 == 1) && (c % 2 == 1);
                p++;
            end
            pend = nxt;
        end
        if (!withhold) begin
            drive(drain_cv, hold_st, 1'b1);
            chk("drn_pvi", pool_valid_in, 0);
            chk("drn_ov", out_valid, 1);
            chk("drn_row", out_row, n / OW);
            chk("drn_col", out_col, n % OW);
            chk("drn_last", frame_last, 1);
            chk("drn_busy", busy, 1);
            chk("drn_done", done, 0);
            n++;
            if (drain_cv) exp_eu = 1'b1;
        end else begin
            for (int k = 0; k < DTO; k++) begin
                drive(1'b0, hold_st, 1'b0);
                chk("tmo_busy", busy, 1);
                chk("tmo_ov", out_valid, 0);
                chk("tmo_done", done, 0);
                chk("tmo_et", err_timeout, 0);
            end
            exp_et = 1'b1;
        end
        drive(1'b0, hold_st, 1'b0);
        chk("done_pulse", done, 1);
        chk("done_busy", busy, 0);
        chk("done_clrn", pool_clr_n, 1);
        chk_errs("done");
        chk("out_count", obs_outs, withhold ? NOUT - 1 : NOUT);
        drive(1'b0, hold_st, 1'b0);
        chk("end_done", done, 0);
        chk("end_busy", busy, 0);
        chk("end_clrn", pool_clr_n, 0);
        chk_errs("end");
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; conv_valid = 1'b0; pool_valid_out = 1'b0;
        #2;
        chk("por_busy", busy, 0);
        chk("por_done", done, 0);
        chk("por_clrn", pool_clr_n, 0);
        chk("por_row", out_row, 0);
        chk("por_col", out_col, 0);
        chk_errs("por");
        @(negedge clk);
        rst_n = 1'b1;

        // Stray pixel while idle: not forwarded, flagged.
        drive(1'b1, 1'b0, 1'b0);
        chk("idlecv_pvi", pool_valid_in, 0);
        chk("idlecv_ov", out_valid, 0);
        exp_eu = 1'b1;
        drive(1'b0, 1'b0, 1'b0);
        chk_errs("idlecv");

        run_frame(100, 1'b0, 1'b0, 1'b0, -1);
        run_frame(50,  1'b0, 1'b0, 1'b0, -1);
        run_frame(100, 1'b0, 1'b0, 1'b1, -1);
        run_frame(60,  1'b1, 1'b0, 1'b0, -1);

        // Start held: the next frame only begins from the idle cycle after done.
        run_frame(100, 1'b0, 1'b1, 1'b0, -1);
        drive(1'b0, 1'b0, 1'b0);
        chk("hs_clr_busy", busy, 1);
        chk("hs_clr_clrn", pool_clr_n, 0);
        drive(1'b0, 1'b0, 1'b0);
        chk("hs_run_clrn", pool_clr_n, 1);
        chk("hs_run_busy", busy, 1);
        do_reset();

        run_frame(100, 1'b0, 1'b0, 1'b0, 300);
        do_reset();
        run_frame(100, 1'b0, 1'b0, 1'b0, -1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
